// File: rtl/unidad_riesgos_pkg.sv
// Shared types and constants for the hazard unit.
// Select encoding: 0 = register file, stage k = k+1.
package unidad_riesgos_pkg;

    localparam int CORTO_NONE = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } estado_t;

    function automatic int sel_width(input int n_fwd);
        return $clog2(n_fwd + 1);
    endfunction

    function automatic int corto_stage(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/unidad_riesgos_comparador_corto.sv
// Per-operand priority encoder: picks the youngest
// candidate stage that writes the source register.
module comparador_corto
    import unidad_riesgos_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int N_FWD      = 2,
    parameter int SEL_W      = sel_width(N_FWD)
) (
    input  logic [REG_ADDR_W-1:0]       src,
    input  logic [N_FWD*REG_ADDR_W-1:0] cand_rd,
    input  logic [N_FWD-1:0]            cand_wr,
    output logic [SEL_W-1:0]            sel
);

    // scan oldest to youngest so the youngest match is the last one written
    always_comb begin
        sel = SEL_W'(CORTO_NONE);
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (cand_wr[k]
                && cand_rd[k*REG_ADDR_W +: REG_ADDR_W] != '0
                && cand_rd[k*REG_ADDR_W +: REG_ADDR_W] == src) begin
                sel = SEL_W'(corto_stage(k));
            end
        end
    end

endmodule

// File: rtl/unidad_riesgos.sv
// Hazard unit: registered forwarding selects for EX
// and counter-driven load-use stall control.
module unidad_riesgos
    import unidad_riesgos_pkg::*;
#(
    parameter  int REG_ADDR_W = 5,
    parameter  int N_SRC      = 2,
    parameter  int N_FWD      = 2,
    parameter  int LOAD_STG   = 1,
    localparam int SEL_W      = sel_width(N_FWD)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_SRC*REG_ADDR_W-1:0] i_src_ID,
    input  logic [N_SRC-1:0]            i_src_used_ID,
    input  logic [REG_ADDR_W-1:0]       i_rd_EX,
    input  logic                        i_write_reg_EX,
    input  logic                        i_mem_read_EX,
    input  logic [N_FWD*REG_ADDR_W-1:0] i_rd_stg,
    input  logic [N_FWD-1:0]            i_write_reg_stg,
    input  logic                        i_freeze,
    input  logic                        i_flush,
    output logic [N_SRC*SEL_W-1:0]      o_corto,
    output logic                        o_stall
);

    localparam int CNT_W = (LOAD_STG > 1) ? $clog2(LOAD_STG + 1) : 1;

    logic [N_FWD*REG_ADDR_W-1:0] cand_rd;
    logic [N_FWD-1:0]            cand_wr;
    logic [N_SRC*SEL_W-1:0]      sel_next;
    logic [N_SRC*SEL_W-1:0]      corto_q;
    logic                        hit;
    logic                        det;
    logic                        stall;
    estado_t                     state_q;
    estado_t                     state_n;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_n;
    logic                        unused_oldest;

    // Next-cycle producers: EX moves to stage 0, stage k-1 moves to k.
    // The current oldest stage retires and is never a candidate.
    if (N_FWD > 1) begin : g_cand
        assign cand_rd = {i_rd_stg[(N_FWD-1)*REG_ADDR_W-1:0], i_rd_EX};
        assign cand_wr = {i_write_reg_stg[N_FWD-2:0], i_write_reg_EX};
    end else begin : g_cand1
        assign cand_rd = i_rd_EX;
        assign cand_wr = i_write_reg_EX;
    end

    assign unused_oldest = ^{i_rd_stg[(N_FWD-1)*REG_ADDR_W +: REG_ADDR_W],
                             i_write_reg_stg[N_FWD-1]};

    for (genvar j = 0; j < N_SRC; j++) begin : g_op
        comparador_corto #(
            .REG_ADDR_W (REG_ADDR_W),
            .N_FWD      (N_FWD),
            .SEL_W      (SEL_W)
        ) u_cmp (
            .src     (i_src_ID[j*REG_ADDR_W +: REG_ADDR_W]),
            .cand_rd (cand_rd),
            .cand_wr (cand_wr),
            .sel     (sel_next[j*SEL_W +: SEL_W])
        );
    end

    // any operand actually read by ID matches the EX load destination
    always_comb begin
        hit = 1'b0;
        for (int j = 0; j < N_SRC; j++) begin
            if (i_src_used_ID[j]
                && i_src_ID[j*REG_ADDR_W +: REG_ADDR_W] == i_rd_EX) begin
                hit = 1'b1;
            end
        end
    end

    assign det = i_mem_read_EX & i_write_reg_EX & (i_rd_EX != '0) & hit;

    // stall FSM state and remaining-cycle counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // next state: long loads keep the stall going for LOAD_STG cycles
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (det && !i_flush && !i_freeze && LOAD_STG > 1) begin
                    state_n = STALL;
                    cnt_n   = CNT_W'(LOAD_STG - 1);
                end
            end
            STALL: begin
                if (i_flush) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (!i_freeze) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // stall output: hazard-driven in IDLE, held high in STALL
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            IDLE:  stall = det & ~i_flush;
            STALL: stall = 1'b1;
        endcase
    end

    // EX selects: bubble clears, freeze holds, otherwise take ID result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            corto_q <= '0;
        end else if (i_flush || stall) begin
            corto_q <= '0;
        end else if (!i_freeze) begin
            corto_q <= sel_next;
        end
    end

    assign o_corto = corto_q;
    assign o_stall = stall;

endmodule

// File: tb/tb_unidad_riesgos.sv
// Bench for unidad_riesgos: two configurations driven in
// parallel, select expectations queued and checked a cycle later.
module tb_unidad_riesgos;

    logic        clk;
    logic        rst_n;
    logic [9:0]  src;
    logic [1:0]  used;
    logic [4:0]  rd_ex;
    logic        wr_ex;
    logic        mr_ex;
    logic [14:0] rd_stg;
    logic [2:0]  wr_stg;
    logic        freeze;
    logic        flush;
    logic [3:0]  corto_a;
    logic [3:0]  corto_b;
    logic        stall_a;
    logic        stall_b;

    int n_chk;
    int n_fail;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    // A: N_FWD=2 (MEM, WB), LOAD_STG=1
    unidad_riesgos #(
        .REG_ADDR_W (5),
        .N_SRC      (2),
        .N_FWD      (2),
        .LOAD_STG   (1)
    ) u_a (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_src_ID        (src),
        .i_src_used_ID   (used),
        .i_rd_EX         (rd_ex),
        .i_write_reg_EX  (wr_ex),
        .i_mem_read_EX   (mr_ex),
        .i_rd_stg        (rd_stg[9:0]),
        .i_write_reg_stg (wr_stg[1:0]),
        .i_freeze        (freeze),
        .i_flush         (flush),
        .o_corto         (corto_a),
        .o_stall         (stall_a)
    );

    // B: N_FWD=3, LOAD_STG=2
    unidad_riesgos #(
        .REG_ADDR_W (5),
        .N_SRC      (2),
        .N_FWD      (3),
        .LOAD_STG   (2)
    ) u_b (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_src_ID        (src),
        .i_src_used_ID   (used),
        .i_rd_EX         (rd_ex),
        .i_write_reg_EX  (wr_ex),
        .i_mem_read_EX   (mr_ex),
        .i_rd_stg        (rd_stg),
        .i_write_reg_stg (wr_stg),
        .i_freeze        (freeze),
        .i_flush         (flush),
        .o_corto         (corto_b),
        .o_stall         (stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] e_rd, input logic e_wr,
                         input logic e_mr, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] sw, input logic frz,
                         input logic fl);
        rd_ex  = e_rd;
        wr_ex  = e_wr;
        mr_ex  = e_mr;
        src    = {rt, rs};
        rd_stg = {s2, s1, s0};
        wr_stg = sw;
        freeze = frz;
        flush  = fl;
    endtask

    // called at posedge+1; stall checked now, selects after the edge
    task automatic step(input int id, input logic [4:0] e_rd,
                        input logic e_wr, input logic e_mr,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] sw,
                        input logic frz, input logic fl,
                        input logic xs_a, input logic xs_b,
                        input logic [3:0] xc_a, input logic [3:0] xc_b);
        logic [3:0] ea;
        logic [3:0] eb;
        drive(e_rd, e_wr, e_mr, rs, rt, s0, s1, s2, sw, frz, fl);
        #2;
        chk($sformatf("s%0d_stall_a", id), 32'(stall_a), 32'(xs_a));
        chk($sformatf("s%0d_stall_b", id), 32'(stall_b), 32'(xs_b));
        q_a.push_back(xc_a);
        q_b.push_back(xc_b);
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk($sformatf("s%0d_corto_a", id), 32'(corto_a), 32'(ea));
        chk($sformatf("s%0d_corto_b", id), 32'(corto_b), 32'(eb));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        used   = 2'b11;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        #2;
        chk("rst_corto_a", 32'(corto_a), 32'h0);
        chk("rst_corto_b", 32'(corto_b), 32'h0);
        chk("rst_stall_a", 32'(stall_a), 32'h0);
        chk("rst_stall_b", 32'(stall_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   id rd w m  rs rt  s0 s1 s2 sw     fz fl  sa sb  ca       cb
        step(1, 3, 1, 0, 3, 5, 0, 0, 0, 3'b000, 0, 0, 0, 0, 4'b0001, 4'b0001);
        step(2, 3, 1, 0, 3, 3, 3, 0, 0, 3'b001, 0, 0, 0, 0, 4'b0101, 4'b0101);
        step(3, 0, 1, 1, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 4'b0000, 4'b0000);
        step(4, 7, 0, 0, 8, 9, 8, 9, 0, 3'b011, 0, 0, 0, 0, 4'b0010, 4'b1110);
        step(5, 3, 1, 0, 3, 5, 0, 0, 0, 3'b000, 1, 0, 0, 0, 4'b0010, 4'b1110);
        step(6, 4, 1, 1, 4, 0, 0, 0, 0, 3'b000, 1, 0, 1, 1, 4'b0000, 4'b0000);
        step(7, 4, 1, 1, 4, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 4'b0000, 4'b0000);
        step(8, 4, 1, 1, 4, 6, 0, 0, 0, 3'b000, 0, 0, 1, 1, 4'b0000, 4'b0000);
        step(9, 0, 0, 0, 4, 6, 4, 0, 0, 3'b001, 0, 0, 0, 1, 4'b0010, 4'b0000);
        step(10, 0, 0, 0, 4, 6, 0, 4, 0, 3'b010, 0, 0, 0, 0, 4'b0000, 4'b0011);
        step(11, 4, 1, 1, 4, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1, 4'b0000, 4'b0000);
        step(12, 0, 0, 0, 4, 0, 4, 0, 0, 3'b001, 1, 0, 0, 1, 4'b0000, 4'b0000);
        step(13, 0, 0, 0, 4, 0, 4, 0, 0, 3'b001, 0, 0, 0, 1, 4'b0010, 4'b0000);
        step(14, 0, 0, 0, 4, 0, 0, 4, 0, 3'b010, 0, 0, 0, 0, 4'b0000, 4'b0011);
        step(15, 4, 1, 1, 4, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 4'b0000, 4'b0000);
        step(16, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 4'b0000, 4'b0000);
        step(17, 4, 1, 1, 4, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1, 4'b0000, 4'b0000);

        // B is now in STALL; reset it asynchronously mid-cycle
        drive(0, 0, 0, 4, 0, 4, 0, 0, 3'b001, 0, 0);
        #2;
        chk("mid_stall_b", 32'(stall_b), 32'h1);
        chk("mid_stall_a", 32'(stall_a), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_stall_b", 32'(stall_b), 32'h0);
        chk("arst_corto_a", 32'(corto_a), 32'h0);
        chk("arst_corto_b", 32'(corto_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(18, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 4'b0000, 4'b0000);
        step(19, 3, 1, 0, 3, 5, 0, 0, 0, 3'b000, 0, 0, 0, 0, 4'b0001, 4'b0001);

        // nonzero selects must clear on async reset without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst2_corto_a", 32'(corto_a), 32'h0);
        chk("arst2_corto_b", 32'(corto_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(20, 3, 1, 0, 3, 3, 3, 0, 0, 3'b001, 0, 0, 0, 0, 4'b0101, 4'b0101);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
